// File: rtl/operand_fwd_unit_pkg.sv
// Shared types for the operand forwarding unit: register addressing,
// forwarding-source indices and the operand-select encoding.
package operand_fwd_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    SRC_EX = 2'd0,
    SRC_ME = 2'd1,
    SRC_WB = 2'd2
  } src_idx_e;

  typedef logic [3:0] opsel_t;

  localparam opsel_t OPSEL_REGFILE = 4'd0;

  // SRC_n is encoded as n+1 so that zero always means "regfile"
  function automatic opsel_t opsel_src(input int idx);
    return opsel_t'(idx + 1);
  endfunction

endpackage

// File: rtl/operand_fwd_unit_fwd_select.sv
// Per-read-port operand resolution: picks the youngest forwarding hit
// and flags the port blocked on pending loads or busy long-latency rd.
module operand_fwd_unit_fwd_select
  import operand_fwd_unit_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NSRC = 3,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]        rs_i,
  input  logic [XLEN-1:0]      rf_data_i,
  input  logic [NSRC-1:0]      src_wen_i,
  input  logic [NSRC*AW-1:0]   src_rd_i,
  input  logic [NSRC*XLEN-1:0] src_data_i,
  input  logic [NSRC-1:0]      src_ok_i,
  input  logic                 busy_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 blocked_o,
  output logic                 hit_o
);

  opsel_t sel;
  logic   any_ok;
  logic   win_ok;
  logic   is_zero;

  assign is_zero = (rs_i == AW'(ZERO_REG));

  // Scan oldest to youngest so the youngest hit is left in sel
  always_comb begin
    sel    = OPSEL_REGFILE;
    any_ok = 1'b0;
    if (!is_zero) begin
      for (int i = NSRC - 1; i >= int'(SRC_EX); i--) begin
        if (src_wen_i[i] && (src_rd_i[i*AW +: AW] == rs_i)) begin
          sel    = opsel_src(i);
          any_ok = any_ok | src_ok_i[i];
        end
      end
    end
  end

  always_comb begin
    data_o = is_zero ? '0 : rf_data_i;
    win_ok = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == opsel_src(i)) begin
        data_o = src_data_i[i*XLEN +: XLEN];
        win_ok = src_ok_i[i];
      end
    end
  end

  assign hit_o     = (sel != OPSEL_REGFILE);
  assign blocked_o = (hit_o && !win_ok) || (busy_i && !any_ok);

endmodule

// File: rtl/operand_fwd_unit.sv
// Operand forwarding unit: scoreboard, decode stall and ID/EX operand register.
// Optional stall/forward statistics are built when FWD_STALL_STAT_EN is defined.
module operand_fwd_unit
  import operand_fwd_unit_pkg::*;
#(
  parameter  int XLEN  = 64,
  parameter  int NREAD = 2,
  parameter  int NSRC  = 3,
  parameter  int NREG  = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [NREAD*AW-1:0]   id_rs_addr,
  input  logic [NREAD*XLEN-1:0] id_rs_data,
  input  logic [NSRC-1:0]       src_wen,
  input  logic [NSRC*AW-1:0]    src_rd_addr,
  input  logic [NSRC*XLEN-1:0]  src_data,
  input  logic [NSRC-1:0]       src_data_ok,
  input  logic                  mc_issue,
  input  logic [AW-1:0]         mc_issue_rd,
  input  logic                  mc_done,
  input  logic [AW-1:0]         mc_done_rd,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [NREAD*XLEN-1:0] ex_rs_data
`ifdef FWD_STALL_STAT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           fwd_hits
`endif
);

  logic [NREG-1:0]       busy_q, busy_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [NREAD*XLEN-1:0] ex_data_q;
  logic [NREAD*XLEN-1:0] res;
  logic [NREAD-1:0]      blk;
  logic [NREAD-1:0]      hit;
  logic                  stall;
  logic                  xfer;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    operand_fwd_unit_fwd_select #(
      .XLEN(XLEN),
      .NSRC(NSRC),
      .AW  (AW)
    ) u_sel (
      .rs_i      (id_rs_addr[p*AW +: AW]),
      .rf_data_i (id_rs_data[p*XLEN +: XLEN]),
      .src_wen_i (src_wen),
      .src_rd_i  (src_rd_addr),
      .src_data_i(src_data),
      .src_ok_i  (src_data_ok),
      .busy_i    (busy_q[id_rs_addr[p*AW +: AW]]),
      .data_o    (res[p*XLEN +: XLEN]),
      .blocked_o (blk[p]),
      .hit_o     (hit[p])
    );
  end

  assign stall    = id_valid && (|blk);
  assign id_ready = !stall && (!ex_valid_q || ex_ready);
  assign xfer     = id_valid && id_ready;

  // Issue is applied after done so a same-register collision stays busy
  always_comb begin
    busy_d = busy_q;
    if (mc_done && (mc_done_rd != AW'(ZERO_REG))) begin
      busy_d[mc_done_rd] = 1'b0;
    end
    if (mc_issue && (mc_issue_rd != AW'(ZERO_REG))) begin
      busy_d[mc_issue_rd] = 1'b1;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (xfer) begin
      ex_valid_d = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_data_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      if (xfer) begin
        ex_data_q <= res;
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs_data = ex_data_q;

`ifdef FWD_STALL_STAT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] hits_q, hits_d;
  logic [32:0] hsum;

  assign hsum = {1'b0, hits_q} + 33'($countones(hit));

  always_comb begin
    stall_d = stall_q;
    hits_d  = hits_q;
    if (stall && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (xfer) begin
      hits_d = hsum[32] ? '1 : hsum[31:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      hits_q  <= '0;
    end else begin
      stall_q <= stall_d;
      hits_q  <= hits_d;
    end
  end

  assign stall_cycles = stall_q;
  assign fwd_hits     = hits_q;
`endif

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Self-checking bench for operand_fwd_unit: directed scenarios plus
// randomized traffic compared each cycle against a behavioural model.
module tb_operand_fwd_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         id_valid;
  logic         id_ready;
  logic [9:0]   id_rs_addr;
  logic [127:0] id_rs_data;
  logic [2:0]   src_wen;
  logic [14:0]  src_rd_addr;
  logic [191:0] src_data;
  logic [2:0]   src_data_ok;
  logic         mc_issue;
  logic [4:0]   mc_issue_rd;
  logic         mc_done;
  logic [4:0]   mc_done_rd;
  logic         flush;
  logic         ex_valid;
  logic         ex_ready;
  logic [127:0] ex_rs_data;
`ifdef FWD_STALL_STAT_EN
  logic [31:0]  stall_cycles;
  logic [31:0]  fwd_hits;
`endif

  operand_fwd_unit dut (
    .clock      (clk),
    .reset      (rst_n),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_rs_addr (id_rs_addr),
    .id_rs_data (id_rs_data),
    .src_wen    (src_wen),
    .src_rd_addr(src_rd_addr),
    .src_data   (src_data),
    .src_data_ok(src_data_ok),
    .mc_issue   (mc_issue),
    .mc_issue_rd(mc_issue_rd),
    .mc_done    (mc_done),
    .mc_done_rd (mc_done_rd),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_rs_data (ex_rs_data)
`ifdef FWD_STALL_STAT_EN
    ,
    .stall_cycles(stall_cycles),
    .fwd_hits    (fwd_hits)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state
  bit          m_busy[32];
  bit          m_valid;
  logic [63:0] m_data[2];

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic void resolve(input int p, output logic [63:0] d,
                                  output bit blk);
    int rs;
    bit found;
    bit wok;
    bit anyok;
    rs    = int'(id_rs_addr[p*5 +: 5]);
    found = 0;
    wok   = 1;
    anyok = 0;
    d     = id_rs_data[p*64 +: 64];
    blk   = 0;
    if (rs == 0) begin
      d = 64'd0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (src_wen[i] && int'(src_rd_addr[i*5 +: 5]) == rs) begin
        if (!found) begin
          found = 1;
          d     = src_data[i*64 +: 64];
          wok   = src_data_ok[i];
        end
        if (src_data_ok[i]) anyok = 1;
      end
    end
    blk = (found && !wok) || (m_busy[rs] && !anyok);
  endfunction

  function automatic bit m_idr();
    logic [63:0] d;
    bit b;
    bit st;
    st = 0;
    for (int p = 0; p < 2; p++) begin
      resolve(p, d, b);
      st = st | b;
    end
    st = st && id_valid;
    return !st && (!m_valid || ex_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_busy[r]) m_busy[r] = 0;
      m_valid = 0;
      m_data[0] = '0;
      m_data[1] = '0;
    end else begin
      logic [63:0] d[2];
      bit b;
      bit xf;
      xf = id_valid && m_idr();
      for (int p = 0; p < 2; p++) resolve(p, d[p], b);
      if (xf) begin
        m_data[0] = d[0];
        m_data[1] = d[1];
      end
      if (flush) m_valid = 0;
      else if (xf) m_valid = 1;
      else if (ex_ready) m_valid = 0;
      if (mc_done && mc_done_rd != 0) m_busy[mc_done_rd] = 0;
      if (mc_issue && mc_issue_rd != 0) m_busy[mc_issue_rd] = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("id_ready", {127'd0, id_ready}, {127'd0, m_idr()});
      check("ex_valid", {127'd0, ex_valid}, {127'd0, m_valid});
      check("ex_rs_data", ex_rs_data, {m_data[1], m_data[0]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_valid    = 0;
    id_rs_addr  = '0;
    id_rs_data  = '0;
    src_wen     = '0;
    src_rd_addr = '0;
    src_data    = '0;
    src_data_ok = '0;
    mc_issue    = 0;
    mc_issue_rd = '0;
    mc_done     = 0;
    mc_done_rd  = '0;
    flush       = 0;
    ex_ready    = 1;
  endtask

  task automatic set_rs(input logic [4:0] rs1, input logic [4:0] rs0);
    id_rs_addr = {rs1, rs0};
  endtask

  task automatic randomize_in();
    id_valid = ($urandom_range(0, 9) < 8);
    set_rs(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    id_rs_data = {$urandom, $urandom, $urandom, $urandom};
    src_wen = 3'($urandom);
    for (int i = 0; i < 3; i++) begin
      src_rd_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
      src_data[i*64 +: 64]  = {$urandom, $urandom};
      src_data_ok[i]        = ($urandom_range(0, 3) != 0);
    end
    mc_issue    = ($urandom_range(0, 99) < 15);
    mc_issue_rd = 5'($urandom_range(0, 7));
    mc_done     = ($urandom_range(0, 99) < 20);
    mc_done_rd  = 5'($urandom_range(0, 7));
    flush       = ($urandom_range(0, 99) < 8);
    ex_ready    = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    clear_in();
    rst_n = 0;
    #12;
    check("rst_ex_valid", {127'd0, ex_valid}, 128'd0);
    check("rst_ex_data", ex_rs_data, 128'd0);
    #4 rst_n = 1;
    chk_en = 1;
    step();

    // No hazard
    id_valid = 1;
    set_rs(5'd6, 5'd5);
    id_rs_data = {64'h22, 64'h11};
    @(negedge clk);
    check("nohaz_ready", {127'd0, id_ready}, 128'd1);
    step();
    id_valid = 0;
    @(negedge clk);
    check("nohaz_valid", {127'd0, ex_valid}, 128'd1);
    check("nohaz_data", ex_rs_data, {64'h22, 64'h11});
    step();

    // Priority: EX beats WB
    clear_in();
    id_valid = 1;
    set_rs(5'd0, 5'd7);
    src_wen = 3'b101;
    src_rd_addr = {5'd7, 5'd0, 5'd7};
    src_data = {64'hBBBB, 64'h0, 64'hAAAA};
    src_data_ok = 3'b111;
    @(negedge clk);
    check("prio_ready", {127'd0, id_ready}, 128'd1);
    step();
    id_valid = 0;
    @(negedge clk);
    check("prio_data", {64'd0, ex_rs_data[63:0]}, 128'hAAAA);
    step();

    // Load-use
    clear_in();
    id_valid = 1;
    set_rs(5'd9, 5'd0);
    src_wen = 3'b001;
    src_rd_addr = {5'd0, 5'd0, 5'd9};
    src_data_ok = 3'b000;
    @(negedge clk);
    check("lu_stall", {127'd0, id_ready}, 128'd0);
    step();
    src_data_ok = 3'b001;
    src_data[63:0] = 64'h1234;
    @(negedge clk);
    check("lu_go", {127'd0, id_ready}, 128'd1);
    step();
    clear_in();
    @(negedge clk);
    check("lu_data", {64'd0, ex_rs_data[127:64]}, 128'h1234);
    step();

    // Scoreboard
    mc_issue = 1;
    mc_issue_rd = 5'd12;
    step();
    mc_issue = 0;
    id_valid = 1;
    set_rs(5'd0, 5'd12);
    @(negedge clk);
    check("sb_stall", {127'd0, id_ready}, 128'd0);
    step();
    mc_done = 1;
    mc_done_rd = 5'd12;
    src_wen = 3'b100;
    src_rd_addr = {5'd12, 5'd0, 5'd0};
    src_data = {64'h55, 128'd0};
    src_data_ok = 3'b100;
    @(negedge clk);
    check("sb_wb_ready", {127'd0, id_ready}, 128'd1);
    step();
    clear_in();
    @(negedge clk);
    check("sb_wb_data", {64'd0, ex_rs_data[63:0]}, 128'h55);
    step();
    mc_issue = 1;
    mc_issue_rd = 5'd3;
    mc_done = 1;
    mc_done_rd = 5'd3;
    step();
    clear_in();
    id_valid = 1;
    set_rs(5'd0, 5'd3);
    @(negedge clk);
    check("sb_setwins", {127'd0, id_ready}, 128'd0);
    step();
    mc_done = 1;
    mc_done_rd = 5'd3;
    step();
    mc_done = 0;
    @(negedge clk);
    check("sb_cleared", {127'd0, id_ready}, 128'd1);
    step();

    // Backpressure and flush
    clear_in();
    id_valid = 1;
    set_rs(5'd2, 5'd1);
    id_rs_data = {64'h0, 64'h77};
    step();
    ex_ready = 0;
    id_rs_data = {64'h0, 64'h88};
    @(negedge clk);
    check("bp_ready", {127'd0, id_ready}, 128'd0);
    check("bp_data", {64'd0, ex_rs_data[63:0]}, 128'h77);
    step();
    @(negedge clk);
    check("bp_hold", {64'd0, ex_rs_data[63:0]}, 128'h77);
    check("bp_valid", {127'd0, ex_valid}, 128'd1);
    step();
    ex_ready = 1;
    flush = 1;
    @(negedge clk);
    check("fl_ready", {127'd0, id_ready}, 128'd1);
    step();
    clear_in();
    @(negedge clk);
    check("fl_valid", {127'd0, ex_valid}, 128'd0);
    step();

    // x0
    id_valid = 1;
    set_rs(5'd0, 5'd0);
    id_rs_data = {64'hDEAD, 64'hBEEF};
    src_wen = 3'b001;
    src_data = {128'd0, 64'hFF};
    src_data_ok = 3'b000;
    @(negedge clk);
    check("x0_ready", {127'd0, id_ready}, 128'd1);
    step();
    clear_in();
    @(negedge clk);
    check("x0_data", ex_rs_data, 128'd0);
    step();

    // Reset mid-stall
    mc_issue = 1;
    mc_issue_rd = 5'd12;
    id_valid = 1;
    set_rs(5'd0, 5'd5);
    step();
    mc_issue = 0;
    set_rs(5'd0, 5'd12);
    @(negedge clk);
    check("rs_pre_stall", {127'd0, id_ready}, 128'd0);
    check("rs_pre_valid", {127'd0, ex_valid}, 128'd1);
    #2 rst_n = 0;
    #1;
    check("rs_valid", {127'd0, ex_valid}, 128'd0);
    check("rs_busy", {127'd0, id_ready}, 128'd1);
    #1 rst_n = 1;
    step();
    clear_in();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      randomize_in();
      if (k == 1500) begin
        #1 rst_n = 0;
        #1 check("rnd_rst", {127'd0, ex_valid}, 128'd0);
        #1 rst_n = 1;
      end
      step();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fwd_unit.md
Name: operand_fwd_unit

Overview:
- Parametrised successor to the single-operand forwarding mux.
- Resolves NREAD source operands against NSRC in-flight pipeline sources, tracks long-latency writers in a register scoreboard, and stalls decode on unresolvable hazards.
- Registers the resolved operands into the ID/EX boundary with a valid/ready handshake.
- Sits between the register file read and the EX stage.

Parameters:
- XLEN, 64, data width.
- NREAD, 2, operand read ports per instruction.
- NSRC, 3, forwarding sources; index 0 is the youngest (EX), NSRC-1 the oldest (WB).
- NREG, 32, architectural registers; address width is clog2(NREG).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds an instruction
- id_ready  out  1  decode may advance
- id_rs_addr  in  NREAD*5  source register addresses
- id_rs_data  in  NREAD*XLEN  register-file read data
- src_wen  in  NSRC  source stage will write rd
- src_rd_addr  in  NSRC*5  source destination addresses
- src_data  in  NSRC*XLEN  source result data
- src_data_ok  in  NSRC  result available now (0 = load pending)
- mc_issue  in  1  long-latency op accepted, marks mc_issue_rd busy
- mc_issue_rd  in  5  destination of the long-latency op
- mc_done  in  1  long-latency op retired, clears mc_done_rd
- mc_done_rd  in  5  destination being cleared
- flush  in  1  kill the EX-side register
- ex_valid  out  1  operand register holds an instruction
- ex_ready  in  1  EX consumes
- ex_rs_data  out  NREAD*XLEN  resolved operands

Behaviour:
- Reset: ex_valid=0, ex_rs_data=0, busy vector=0. Outputs are not driven by a clock edge until reset deasserts.
- Per-port resolution is combinational. Hit on source i means src_wen[i] && src_rd_addr[i]==rs && rs!=0.
  - Lowest-index hit wins.
  - No hit: use id_rs_data.
  - rs==0: value is always 0 and never hits or stalls.
- A port is blocked when either:
  - its winning hit has src_data_ok=0, or
  - busy[rs]=1 and no source hit carries data_ok=1 for rs.
- stall = id_valid && any port blocked.
- id_ready = !stall && (!ex_valid || ex_ready).
- Transfer on id_valid && id_ready: ex_rs_data <= resolved values and ex_valid <= 1. This gives 1-cycle latency.
- If ex_valid && ex_ready and there is no transfer, ex_valid <= 0.
- If EX is blocked (ex_valid && !ex_ready), ex_rs_data holds.
- flush: ex_valid <= 0 next edge; flush has priority over a transfer the same cycle.
- Scoreboard:
  - mc_issue sets busy[mc_issue_rd].
  - mc_done clears busy[mc_done_rd].
  - Same register in the same cycle: set wins.
  - rd==0 is ignored.
  - Clearing an idle register is a no-op.
- Reset mid-stall: busy is cleared and ex_valid=0 asynchronously.

Optional Feature:
- Macro FWD_STALL_STAT_EN.
- When defined:
  - Adds outputs stall_cycles (32) and fwd_hits (32).
  - stall_cycles increments each cycle stall=1.
  - fwd_hits increments by the number of ports served by a source on each transfer.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined: neither port nor counter exists, and function is otherwise identical.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5 and ZERO_REG.
  - A source-index enum: SRC_EX=0, SRC_ME=1, SRC_WB=2.
  - An operand-select encoding (REGFILE, SRC_n).
- One natural sub-module, fwd_select: combinational, one per read port via generate. It produces the resolved data and the blocked flag.
- The top module owns the scoreboard, the handshake and the EX register.

Test Plan:
- No hazard: rs1=5, rs2=6, id_rs_data=0x11/0x22, no src_wen → next cycle ex_valid=1, ex_rs_data={0x22,0x11}.
- Priority: EX and WB both write x7 (0xAAAA / 0xBBBB), rs1=7 → ex_rs_data[0]=0xAAAA.
- Load-use: src_wen[0]=1, rd=9, data_ok=0, rs2=9 → id_ready=0 for one cycle. Then data_ok=1 with 0x1234 → transfer and ex_rs_data[1]=0x1234.
- Scoreboard: mc_issue rd=12, then rs1=12 → stall. On the same cycle mc_done rd=12 and WB supplies 0x55 with data_ok → transfer 0x55. mc_issue and mc_done both on rd=3 in one cycle → busy[3] stays 1.
- Backpressure and flush: ex_ready=0 with ex_valid=1 → id_ready=0 and data held. flush together with id_valid && id_ready → ex_valid=0.
- x0 and reset: rs1=0 while src_wen with rd=0 data=0xFF → operand 0, no stall. Assert reset mid-stall → ex_valid=0 and busy cleared immediately.
